// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480 vertical line counts and state helpers for the
// VGA vertical timing generator.
package vga_timing_pkg;

    // One-hot vertical phase encoding
    typedef enum logic [3:0] {
        ST_SYNC   = 4'b0001,
        ST_BP     = 4'b0010,
        ST_ACTIVE = 4'b0100,
        ST_FRONT  = 4'b1000
    } vstate_e;

    // Default 640x480@60 vertical timing, in lines
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 29;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_ROW_REPEAT = 5;

    // Number of line steps spent in a given phase
    function automatic int unsigned state_len(input vstate_e     st,
                                              input int unsigned sync_len,
                                              input int unsigned bp_len,
                                              input int unsigned active_len,
                                              input int unsigned fp_len);
        unique case (st)
            ST_SYNC:   return sync_len;
            ST_BP:     return bp_len;
            ST_ACTIVE: return active_len;
            default:   return fp_len;
        endcase
    endfunction

    // Phase that follows the given one
    function automatic vstate_e next_state(input vstate_e st);
        unique case (st)
            ST_SYNC:   return ST_BP;
            ST_BP:     return ST_ACTIVE;
            ST_ACTIVE: return ST_FRONT;
            default:   return ST_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/vga_row_scaler.sv
// Frame-buffer row address generator: holds each memory row for ROW_REPEAT
// display lines, then advances to the next row.
module vga_row_scaler #(
    parameter int unsigned ROW_REPEAT = 5,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              clear,
    output logic [ADDR_W-1:0] addr
);

    localparam int unsigned REP_W = (ROW_REPEAT > 1) ? $clog2(ROW_REPEAT) : 1;

    logic [REP_W-1:0]  rep_q;
    logic [ADDR_W-1:0] addr_q;

    // Repeat counter and row address; clear wins over step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_q  <= '0;
            addr_q <= '0;
        end else if (clear) begin
            rep_q  <= '0;
            addr_q <= '0;
        end else if (step) begin
            if (rep_q == REP_W'(ROW_REPEAT - 1)) begin
                rep_q  <= '0;
                addr_q <= addr_q + ADDR_W'(1);
            end else begin
                rep_q <= rep_q + REP_W'(1);
            end
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/vga_vtiming_gen.sv
// Vertical timing generator: steps once per accepted line_tick through
// SYNC -> BP -> ACTIVE -> FRONT and drives registered vsync/vblank/row outputs.
module vga_vtiming_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned ROW_REPEAT = DEF_ROW_REPEAT,
    parameter int unsigned ADDR_W     = 7,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned LCNT_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              line_tick,
    output logic              vga_vsync,
    output logic              vblank,
    output logic              read_mem_vertical,
    output logic [ADDR_W-1:0] vertical_pixel_addr,
    output logic              frame_start
);

    // Elaboration-time parameter sanity checks
    if (V_SYNC < 1 || V_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || ROW_REPEAT < 1) begin : g_err_len
        $error("vga_vtiming_gen: every length parameter must be >= 1");
    end
    if (ROW_REPEAT >= 1 && (V_ACTIVE % ROW_REPEAT) != 0) begin : g_err_rep
        $error("vga_vtiming_gen: V_ACTIVE must be a multiple of ROW_REPEAT");
    end
    if (ROW_REPEAT >= 1 && (V_ACTIVE / ROW_REPEAT) > (2 ** ADDR_W)) begin : g_err_addr
        $error("vga_vtiming_gen: ADDR_W too narrow for V_ACTIVE/ROW_REPEAT rows");
    end
    if ((2 ** LCNT_W) <= V_SYNC || (2 ** LCNT_W) <= V_BP ||
        (2 ** LCNT_W) <= V_ACTIVE || (2 ** LCNT_W) <= V_FP) begin : g_err_lcnt
        $error("vga_vtiming_gen: LCNT_W too narrow for the longest phase");
    end

    vstate_e           state_q;
    vstate_e           state_nxt;
    logic [LCNT_W-1:0] line_cnt_q;
    logic [LCNT_W-1:0] len_m1;
    logic              tick;
    logic              cnt_last;
    logic              row_step;
    logic              row_clear;
    logic              vsync_q;
    logic              vblank_q;
    logic              read_mem_q;
    logic              frame_start_q;

    // Step qualification, end-of-phase detect and row scaler controls
    always_comb begin
        tick      = en && line_tick;
        len_m1    = LCNT_W'(state_len(state_q, V_SYNC, V_BP, V_ACTIVE, V_FP) - 1);
        cnt_last  = (line_cnt_q == len_m1);
        state_nxt = next_state(state_q);
        row_step  = tick && (state_q == ST_ACTIVE) && !cnt_last;
        // Leaving ACTIVE returns the row address to 0 on the same edge
        row_clear = tick && (state_q == ST_ACTIVE) && cnt_last;
    end

    // Phase FSM, line counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Parked on the last FRONT line so the first step opens a frame
            state_q       <= ST_FRONT;
            line_cnt_q    <= LCNT_W'(V_FP - 1);
            vsync_q       <= ~SYNC_POL;
            vblank_q      <= 1'b1;
            read_mem_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (tick) begin
                if (cnt_last) begin
                    state_q       <= state_nxt;
                    line_cnt_q    <= '0;
                    vsync_q       <= (state_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
                    vblank_q      <= (state_nxt != ST_ACTIVE);
                    read_mem_q    <= (state_nxt == ST_ACTIVE);
                    frame_start_q <= (state_nxt == ST_SYNC);
                end else begin
                    line_cnt_q <= line_cnt_q + LCNT_W'(1);
                end
            end
        end
    end

    vga_row_scaler #(
        .ROW_REPEAT (ROW_REPEAT),
        .ADDR_W     (ADDR_W)
    ) u_row_scaler (
        .clk   (clk),
        .reset (reset),
        .step  (row_step),
        .clear (row_clear),
        .addr  (vertical_pixel_addr)
    );

    assign vga_vsync         = vsync_q;
    assign vblank            = vblank_q;
    assign read_mem_vertical = read_mem_q;
    assign frame_start       = frame_start_q;

endmodule

// File: tb/tb_vga_vtiming_gen.sv
// Bench for vga_vtiming_gen: a small configuration and the default 640x480
// configuration, both checked against a frame-position arithmetic model.
module tb_vga_vtiming_gen;

    typedef struct packed {
        logic       vs;
        logic       vb;
        logic       rd;
        logic [7:0] addr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small configuration DUT
    logic       s_reset, s_en, s_tick;
    logic       s_vsync, s_vblank, s_rd, s_fs;
    logic [1:0] s_addr;

    // Default configuration DUT
    logic       d_reset, d_en, d_tick;
    logic       d_vsync, d_vblank, d_rd, d_fs;
    logic [6:0] d_addr;

    vga_vtiming_gen #(
        .V_SYNC     (2),
        .V_BP       (3),
        .V_ACTIVE   (6),
        .V_FP       (1),
        .ROW_REPEAT (2),
        .ADDR_W     (2),
        .SYNC_POL   (1'b0),
        .LCNT_W     (10)
    ) u_small (
        .clk                 (clk),
        .reset               (s_reset),
        .en                  (s_en),
        .line_tick           (s_tick),
        .vga_vsync           (s_vsync),
        .vblank              (s_vblank),
        .read_mem_vertical   (s_rd),
        .vertical_pixel_addr (s_addr),
        .frame_start         (s_fs)
    );

    vga_vtiming_gen u_dflt (
        .clk                 (clk),
        .reset               (d_reset),
        .en                  (d_en),
        .line_tick           (d_tick),
        .vga_vsync           (d_vsync),
        .vblank              (d_vblank),
        .read_mem_vertical   (d_rd),
        .vertical_pixel_addr (d_addr),
        .frame_start         (d_fs)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Small-config model state: accepted steps since reset, raw ticks, frame length
    int unsigned s_k = 0, s_ticks = 0, s_fs_mark = 0, s_frame_len = 0;
    // Default-config model state
    int unsigned d_k = 0, d_fs_mark = 0, d_frame_len = 0, d_frames = 0, d_max_addr = 0;

    // Expected outputs after k accepted steps: step 1 is the first SYNC line
    function automatic exp_t model(input int unsigned k, input int unsigned s,
                                   input int unsigned b, input int unsigned a,
                                   input int unsigned f, input int unsigned r);
        exp_t        e;
        int unsigned p;
        e.vs   = 1'b1;
        e.vb   = 1'b1;
        e.rd   = 1'b0;
        e.addr = 8'd0;
        if (k != 0) begin
            p    = (k - 1) % (s + b + a + f);
            e.vs = (p < s) ? 1'b0 : 1'b1;
            if (p >= s + b && p < s + b + a) begin
                e.vb   = 1'b0;
                e.rd   = 1'b1;
                e.addr = 8'((p - s - b) / r);
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic s_compare(input logic fs_exp);
        exp_t x;
        x = model(s_k, 2, 3, 6, 1, 2);
        check("s_vsync", 32'(s_vsync), 32'(x.vs));
        check("s_vblank", 32'(s_vblank), 32'(x.vb));
        check("s_read_mem", 32'(s_rd), 32'(x.rd));
        check("s_addr", 32'(s_addr), 32'(x.addr));
        check("s_frame_start", 32'(s_fs), 32'(fs_exp));
    endtask

    // One clock on the small DUT; inputs held across the posedge, checked at negedge
    task automatic s_cycle(input logic e, input logic t);
        logic acc;
        s_en   = e;
        s_tick = t;
        @(posedge clk);
        acc = e && t && s_reset;
        if (acc) s_k++;
        if (t) s_ticks++;
        @(negedge clk);
        s_compare(acc && ((s_k - 1) % 12 == 0));
        if (s_fs === 1'b1) begin
            s_frame_len = s_ticks - s_fs_mark;
            s_fs_mark   = s_ticks;
        end
    endtask

    task automatic d_cycle(input logic e, input logic t);
        logic acc;
        exp_t x;
        d_en   = e;
        d_tick = t;
        @(posedge clk);
        acc = e && t;
        if (acc) d_k++;
        @(negedge clk);
        x = model(d_k, 2, 29, 480, 10, 5);
        check("d_vsync", 32'(d_vsync), 32'(x.vs));
        check("d_vblank", 32'(d_vblank), 32'(x.vb));
        check("d_read_mem", 32'(d_rd), 32'(x.rd));
        check("d_addr", 32'(d_addr), 32'(x.addr));
        check("d_frame_start", 32'(d_fs), 32'(acc && ((d_k - 1) % 521 == 0)));
        if (32'(d_addr) > d_max_addr) d_max_addr = 32'(d_addr);
        if (d_fs === 1'b1) begin
            d_frames++;
            if (d_fs_mark != 0) d_frame_len = d_k - d_fs_mark;
            d_fs_mark = d_k;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  j;
        logic seen;
        s_reset = 1'b0;
        s_en    = 1'b0;
        s_tick  = 1'b0;
        d_reset = 1'b0;
        d_en    = 1'b0;
        d_tick  = 1'b0;

        // Reset state, including a tick presented while reset is held
        s_cycle(1'b0, 1'b0);
        s_cycle(1'b1, 1'b1);
        s_reset = 1'b1;
        s_cycle(1'b1, 1'b0);

        // Baseline: 13 ticks spaced 4 clocks apart
        for (int i = 1; i <= 13; i++) begin
            s_cycle(1'b1, 1'b1);
            repeat (3) s_cycle(1'b1, 1'b0);
        end
        check("frame_len_base", s_frame_len, 12);

        // en held low across three ticks mid-ACTIVE stretches the frame to 15 ticks
        j    = 0;
        seen = 1'b0;
        while (!seen && j < 40) begin
            s_cycle(!(j >= 7 && j < 10), 1'b1);
            if (s_fs === 1'b1) seen = 1'b1;
            s_cycle(1'b1, 1'b0);
            j++;
        end
        check("gated_frame_seen", 32'(seen), 1);
        check("frame_len_gated", s_frame_len, 15);

        // Back-to-back ticks: a full frame in 12 consecutive cycles
        repeat (12) s_cycle(1'b1, 1'b1);
        check("frame_len_b2b", s_frame_len, 12);
        s_cycle(1'b1, 1'b0);

        // Async reset asserted between clocks while in ACTIVE
        repeat (7) s_cycle(1'b1, 1'b1);
        check("pre_reset_active", 32'(s_rd), 1);
        #2 s_reset = 1'b0;
        #1;
        s_k       = 0;
        s_ticks   = 0;
        s_fs_mark = 0;
        s_compare(1'b0);
        s_cycle(1'b0, 1'b0);
        s_reset = 1'b1;
        s_cycle(1'b1, 1'b1);
        check("fs_after_reset", 32'(s_fs), 1);

        // Randomised en/tick traffic
        repeat (400) s_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

        // Default configuration: two full frames with sparse en drop-outs
        d_reset = 1'b1;
        repeat (1150) d_cycle($urandom_range(0, 9) != 0, 1'b1);
        check("d_frames_seen", 32'(d_frames >= 2), 1);
        check("d_frame_len", d_frame_len, 521);
        check("d_max_addr", d_max_addr, 95);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
